bitwise_and_checker: RTL and testbench

Synthesizable self-checking monitor for the registered bitwise-AND datapath (`c <= a & b`). It observes the same `a`, `b` and `c` buses that feed and leave the AND stage, and predicts `c` from `a` and `b` through a delay line matched to the stage latency. It compares a programmed number of results and reports counts, the first mismatch and a pass/fail verdict. It sits beside the AND stage in simulation and on-chip bring-up, replacing ad-hoc waveform inspection.

---
 rtl/bitwise_and_checker_if.sv | 33 +++
 rtl/bitwise_and_checker.sv | 134 +++++++++++++
 tb/tb_bitwise_and_checker.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitwise_and_checker_if.sv
// Bus bundle between an AND-stage environment and bitwise_and_checker.
// The environment drives the observed operands/result and run control; the checker drives status.
interface bitwise_and_checker_if #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 start;
  logic [CNT_WIDTH-1:0] num_checks;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     c;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CNT_WIDTH-1:0] check_cnt;
  logic [CNT_WIDTH-1:0] err_cnt;
  logic                 first_err_valid;
  logic [WIDTH-1:0]     first_err_exp;
  logic [WIDTH-1:0]     first_err_got;
  logic [CNT_WIDTH-1:0] first_err_idx;

  modport master (
    output start, num_checks, a, b, c,
    input  busy, done, pass, check_cnt, err_cnt,
    input  first_err_valid, first_err_exp, first_err_got, first_err_idx
  );

  modport slave (
    input  start, num_checks, a, b, c,
    output busy, done, pass, check_cnt, err_cnt,
    output first_err_valid, first_err_exp, first_err_got, first_err_idx
  );
endinterface

// File: rtl/bitwise_and_checker.sv
// Self-checking monitor for a registered c <= a & b stage: predicts c through a matched
// delay line, compares a programmed number of results and reports counts and first mismatch.
module bitwise_and_checker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  bitwise_and_checker_if.slave bus
);

  localparam int unsigned PW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StPrime, StCheck, StDone} state_e;

  state_e                   state_q;
  logic [LATENCY*WIDTH-1:0] pipe_q;
  logic [WIDTH-1:0]         exp_q;
  logic [PW-1:0]            prime_q;
  logic [CNT_WIDTH-1:0]     num_q;
  logic [CNT_WIDTH-1:0]     check_cnt_q;
  logic [CNT_WIDTH-1:0]     err_cnt_q;
  logic [CNT_WIDTH-1:0]     first_idx_q;
  logic [WIDTH-1:0]         first_exp_q;
  logic [WIDTH-1:0]         first_got_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     pass_q;
  logic                     first_valid_q;

  logic                     mismatch;
  logic [CNT_WIDTH-1:0]     check_inc;
  logic [CNT_WIDTH-1:0]     err_next;

  // Expected-value delay line runs in every state so it is primed before each run.
  if (LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= bus.a & bus.b;
    end
  end else begin : g_latn
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= {pipe_q[(LATENCY-1)*WIDTH-1:0], bus.a & bus.b};
    end
  end

  assign exp_q = pipe_q[LATENCY*WIDTH-1 -: WIDTH];

  always_comb begin
    mismatch  = (bus.c != exp_q);
    check_inc = check_cnt_q + CNT_WIDTH'(1);
    err_next  = err_cnt_q;
    if (mismatch && (err_cnt_q != '1)) err_next = err_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      prime_q       <= '0;
      num_q         <= '0;
      check_cnt_q   <= '0;
      err_cnt_q     <= '0;
      first_idx_q   <= '0;
      first_exp_q   <= '0;
      first_got_q   <= '0;
      first_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            check_cnt_q   <= '0;
            err_cnt_q     <= '0;
            first_idx_q   <= '0;
            first_exp_q   <= '0;
            first_got_q   <= '0;
            first_valid_q <= 1'b0;
            num_q         <= bus.num_checks;
            if (bus.num_checks == '0) begin
              pass_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              pass_q  <= 1'b0;
              busy_q  <= 1'b1;
              prime_q <= '0;
              state_q <= StPrime;
            end
          end
        end
        StPrime: begin
          if (prime_q == PW'(LATENCY - 1)) state_q <= StCheck;
          else                             prime_q <= prime_q + PW'(1);
        end
        StCheck: begin
          check_cnt_q <= check_inc;
          err_cnt_q   <= err_next;
          if (mismatch && !first_valid_q) begin
            first_exp_q   <= exp_q;
            first_got_q   <= bus.c;
            first_idx_q   <= check_cnt_q;
            first_valid_q <= 1'b1;
          end
          if (check_inc == num_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_next == '0);
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.check_cnt       = check_cnt_q;
  assign bus.err_cnt         = err_cnt_q;
  assign bus.first_err_valid = first_valid_q;
  assign bus.first_err_exp   = first_exp_q;
  assign bus.first_err_got   = first_got_q;
  assign bus.first_err_idx   = first_idx_q;

endmodule

// File: tb/tb_bitwise_and_checker.sv
// Directed bench for bitwise_and_checker: a behavioural AND stage feeds three checker
// instances (main, 4-bit counters at latency 1, 4-bit counters at latency 3).
module tb_bitwise_and_checker;
  localparam int unsigned W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         fault = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  bitwise_and_checker_if #(.WIDTH(W), .CNT_WIDTH(16)) if_m ();
  bitwise_and_checker_if #(.WIDTH(W), .CNT_WIDTH(4))  if_s1 ();
  bitwise_and_checker_if #(.WIDTH(W), .CNT_WIDTH(4))  if_s3 ();

  bitwise_and_checker #(.WIDTH(W), .LATENCY(1), .CNT_WIDTH(16)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(if_m)
  );
  bitwise_and_checker #(.WIDTH(W), .LATENCY(1), .CNT_WIDTH(4)) u_sat1 (
    .clk(clk), .rst_n(rst_n), .bus(if_s1)
  );
  bitwise_and_checker #(.WIDTH(W), .LATENCY(3), .CNT_WIDTH(4)) u_sat3 (
    .clk(clk), .rst_n(rst_n), .bus(if_s3)
  );

  // Reference AND stages: 1-deep for the latency-1 checkers, 3-deep for the latency-3 one.
  logic [W-1:0] stage1_q = '0;
  logic [W-1:0] stage3_q [3] = '{default: '0};
  always @(posedge clk) begin
    stage1_q    <= a & b;
    stage3_q[0] <= a & b;
    stage3_q[1] <= stage3_q[0];
    stage3_q[2] <= stage3_q[1];
  end

  assign if_m.a  = a;
  assign if_m.b  = b;
  assign if_s1.a = a;
  assign if_s1.b = b;
  assign if_s3.a = a;
  assign if_s3.b = b;
  assign if_m.c  = stage1_q | {{(W-1){1'b0}}, fault};
  assign if_s1.c = ~stage1_q;
  assign if_s3.c = ~stage3_q[2];

  task automatic kick_main(input logic [15:0] n);
    @(negedge clk);
    if_m.start      = 1'b1;
    if_m.num_checks = n;
    @(posedge clk);
    #1;
  endtask

  task automatic step_main(input bit zero_ops);
    @(negedge clk);
    if_m.start = 1'b0;
    a = zero_ops ? '0 : W'($urandom);
    b = zero_ops ? '0 : W'($urandom);
    @(posedge clk);
    #1;
  endtask

  // Steps the main checker until done (bounded); cycle 1 is the cycle after the start cycle.
  task automatic run_main(input bit zero_ops, input int pulse_at, output int cyc,
                          output bit busy_bad, output bit prog_bad);
    int want;
    cyc = 1; busy_bad = 1'b0; prog_bad = 1'b0;
    while (cyc < 200) begin
      if (if_m.done === 1'b1) break;
      if (if_m.busy !== 1'b1) busy_bad = 1'b1;
      want = (cyc > 2) ? cyc - 2 : 0;
      if (if_m.check_cnt !== 16'(want)) prog_bad = 1'b1;
      @(negedge clk);
      if_m.start = (cyc == pulse_at);
      if (cyc == pulse_at) if_m.num_checks = 16'd3;
      a = zero_ops ? '0 : W'($urandom);
      b = zero_ops ? '0 : W'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({if_m.busy, if_m.done, if_m.pass, if_m.first_err_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {if_m.busy, if_m.done, if_m.pass, if_m.first_err_valid});
    end
    n_cmp++;
    if ({if_m.check_cnt, if_m.err_cnt, if_m.first_err_idx} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_counters: got %h want 0",
               {if_m.check_cnt, if_m.err_cnt, if_m.first_err_idx});
    end
    n_cmp++;
    if ({if_m.first_err_exp, if_m.first_err_got} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_first_err: got %h want 00", {if_m.first_err_exp, if_m.first_err_got});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_matched();
    int cyc; bit busy_bad; bit prog_bad;
    kick_main(16'd50);
    run_main(1'b0, -1, cyc, busy_bad, prog_bad);
    n_cmp++;
    if (cyc !== 52) begin n_bad++; $display("FAIL matched_latency: got %0d want 52", cyc); end
    n_cmp++;
    if (busy_bad || prog_bad) begin
      n_bad++;
      $display("FAIL matched_progress: busy_bad=%0d prog_bad=%0d want 0/0", busy_bad, prog_bad);
    end
    n_cmp++;
    if (if_m.check_cnt !== 16'd50) begin
      n_bad++; $display("FAIL matched_check_cnt: got %0d want 50", if_m.check_cnt);
    end
    n_cmp++;
    if ({if_m.busy, if_m.pass, if_m.first_err_valid} !== 3'b010 || if_m.err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL matched_verdict: busy/pass/fev=%b err=%0d want 010 err=0",
               {if_m.busy, if_m.pass, if_m.first_err_valid}, if_m.err_cnt);
    end
    repeat (3) step_main(1'b0);
    n_cmp++;
    if (if_m.done !== 1'b0 || if_m.pass !== 1'b1 || if_m.check_cnt !== 16'd50) begin
      n_bad++;
      $display("FAIL matched_hold: done=%b pass=%b cnt=%0d want 0 1 50",
               if_m.done, if_m.pass, if_m.check_cnt);
    end
  endtask

  task automatic test_fault();
    int cyc; bit busy_bad; bit prog_bad;
    @(negedge clk);
    a = '0; b = '0; fault = 1'b1;
    kick_main(16'd10);
    run_main(1'b1, -1, cyc, busy_bad, prog_bad);
    n_cmp++;
    if (cyc !== 12) begin n_bad++; $display("FAIL fault_latency: got %0d want 12", cyc); end
    n_cmp++;
    if (if_m.err_cnt !== 16'd10) begin
      n_bad++; $display("FAIL fault_err_cnt: got %0d want 10", if_m.err_cnt);
    end
    n_cmp++;
    if (if_m.first_err_exp !== 4'h0 || if_m.first_err_got !== 4'h1) begin
      n_bad++;
      $display("FAIL fault_first_err: exp=%h got=%h want 0 1",
               if_m.first_err_exp, if_m.first_err_got);
    end
    n_cmp++;
    if (if_m.first_err_idx !== 16'd0 || if_m.first_err_valid !== 1'b1 || if_m.pass !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_verdict: idx=%0d fev=%b pass=%b want 0 1 0",
               if_m.first_err_idx, if_m.first_err_valid, if_m.pass);
    end
    @(negedge clk);
    fault = 1'b0;
  endtask

  task automatic test_zero_length();
    kick_main(16'd0);
    n_cmp++;
    if ({if_m.done, if_m.busy, if_m.pass, if_m.first_err_valid} !== 4'b1010) begin
      n_bad++;
      $display("FAIL zero_flags: done/busy/pass/fev=%b want 1010",
               {if_m.done, if_m.busy, if_m.pass, if_m.first_err_valid});
    end
    n_cmp++;
    if (if_m.check_cnt !== 16'd0 || if_m.err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL zero_counters: cnt=%0d err=%0d want 0 0", if_m.check_cnt, if_m.err_cnt);
    end
    step_main(1'b0);
    n_cmp++;
    if (if_m.done !== 1'b0 || if_m.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_after: done=%b busy=%b want 0 0", if_m.done, if_m.busy);
    end
  endtask

  task automatic test_start_ignored();
    int cyc; int dones; bit busy_bad; bit prog_bad;
    kick_main(16'd20);
    run_main(1'b0, 8, cyc, busy_bad, prog_bad);
    dones = (if_m.done === 1'b1) ? 1 : 0;
    repeat (6) begin
      step_main(1'b0);
      if (if_m.done === 1'b1) dones++;
    end
    n_cmp++;
    if (cyc !== 22 || prog_bad) begin
      n_bad++; $display("FAIL restart_latency: got %0d prog_bad=%0d want 22 0", cyc, prog_bad);
    end
    n_cmp++;
    if (if_m.check_cnt !== 16'd20) begin
      n_bad++; $display("FAIL restart_check_cnt: got %0d want 20", if_m.check_cnt);
    end
    n_cmp++;
    if (dones !== 1) begin n_bad++; $display("FAIL restart_done_pulses: got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid_run();
    int cyc; int dones; bit busy_bad; bit prog_bad;
    kick_main(16'd20);
    for (int i = 0; i < 20 && if_m.check_cnt !== 16'd5; i++) step_main(1'b0);
    n_cmp++;
    if (if_m.check_cnt !== 16'd5 || if_m.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_reach: cnt=%0d busy=%b want 5 1", if_m.check_cnt, if_m.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if_m.busy, if_m.done, if_m.pass, if_m.first_err_valid} !== 4'b0000 ||
        if_m.check_cnt !== 16'd0 || if_m.err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL midrst_clear: flags=%b cnt=%0d err=%0d want 0000 0 0",
               {if_m.busy, if_m.done, if_m.pass, if_m.first_err_valid},
               if_m.check_cnt, if_m.err_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (25) begin
      step_main(1'b0);
      if (if_m.done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
    kick_main(16'd8);
    run_main(1'b0, -1, cyc, busy_bad, prog_bad);
    n_cmp++;
    if (cyc !== 10 || if_m.pass !== 1'b1 || if_m.check_cnt !== 16'd8 || if_m.err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL midrst_rerun: cyc=%0d pass=%b cnt=%0d err=%0d want 10 1 8 0",
               cyc, if_m.pass, if_m.check_cnt, if_m.err_cnt);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    @(negedge clk);
    if_s1.start = 1'b1; if_s1.num_checks = 4'd15;
    @(posedge clk);
    #1;
    cyc = 1;
    while (cyc < 100 && if_s1.done !== 1'b1) begin
      @(negedge clk);
      if_s1.start = 1'b0; a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (cyc !== 17) begin n_bad++; $display("FAIL sat1_latency: got %0d want 17", cyc); end
    n_cmp++;
    if (if_s1.err_cnt !== 4'hF || if_s1.check_cnt !== 4'hF || if_s1.pass !== 1'b0) begin
      n_bad++;
      $display("FAIL sat1_counts: err=%0d cnt=%0d pass=%b want 15 15 0",
               if_s1.err_cnt, if_s1.check_cnt, if_s1.pass);
    end
    repeat (3) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (if_s1.err_cnt !== 4'hF || if_s1.done !== 1'b0) begin
      n_bad++;
      $display("FAIL sat1_hold: err=%0d done=%b want 15 0", if_s1.err_cnt, if_s1.done);
    end

    @(negedge clk);
    if_s3.start = 1'b1; if_s3.num_checks = 4'd12;
    @(posedge clk);
    #1;
    cyc = 1;
    while (cyc < 100 && if_s3.done !== 1'b1) begin
      @(negedge clk);
      if_s3.start = 1'b0; a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (cyc !== 16) begin n_bad++; $display("FAIL sat3_latency: got %0d want 16", cyc); end
    n_cmp++;
    if (if_s3.err_cnt !== 4'd12 || if_s3.check_cnt !== 4'd12 || if_s3.pass !== 1'b0) begin
      n_bad++;
      $display("FAIL sat3_counts: err=%0d cnt=%0d pass=%b want 12 12 0",
               if_s3.err_cnt, if_s3.check_cnt, if_s3.pass);
    end
    n_cmp++;
    if (if_s3.first_err_valid !== 1'b1 || if_s3.first_err_idx !== 4'd0) begin
      n_bad++;
      $display("FAIL sat3_first_err: fev=%b idx=%0d want 1 0",
               if_s3.first_err_valid, if_s3.first_err_idx);
    end
  endtask

  initial begin
    if_m.start  = 1'b0; if_m.num_checks  = '0;
    if_s1.start = 1'b0; if_s1.num_checks = '0;
    if_s3.start = 1'b0; if_s3.num_checks = '0;
    test_reset();
    test_matched();
    test_fault();
    test_zero_length();
    test_start_ignored();
    test_reset_mid_run();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
